// File: rtl/monitor_pkg.sv
// Shared constants and types for the glyph row loader and its shadow buffer.
// Frame geometry, FSM state encoding and the blank-row value used at reset.
package monitor_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned WIDTH = 8;

  typedef enum logic {
    StFill    = 1'b0,
    StPending = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] BlankRow = '0;

endpackage

// File: rtl/glyph_shadow_buffer.sv
// ROWS x WIDTH write-indexed register file with a flat parallel read-out.
// Holds the frame being assembled until the loader swaps it into the active rows.
module glyph_shadow_buffer
  import monitor_pkg::*;
#(
  parameter int unsigned ROWS  = monitor_pkg::ROWS,
  parameter int unsigned WIDTH = monitor_pkg::WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(ROWS)-1:0]    wr_idx,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [ROWS-1:0][WIDTH-1:0] rd_rows
);

  logic [ROWS-1:0][WIDTH-1:0] buf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        buf_q[i] <= BlankRow;
      end
    end else if (wr_en) begin
      buf_q[wr_idx] <= wr_data;
    end
  end

  assign rd_rows = buf_q;

endmodule

// File: rtl/glyph_row_loader.sv
// Assembles one glyph frame per ROWS bytes in a shadow buffer and swaps it into
// stable row outputs only at a frame boundary, so the monitor never sees a partial frame.
module glyph_row_loader
  import monitor_pkg::*;
#(
  parameter int unsigned ROWS      = monitor_pkg::ROWS,
  parameter int unsigned WIDTH     = monitor_pkg::WIDTH,
  parameter bit          SYNC_SWAP = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] row_0,
  output logic [WIDTH-1:0] row_1,
  output logic [WIDTH-1:0] row_2,
  output logic [WIDTH-1:0] row_3,
  output logic [WIDTH-1:0] row_4,
  output logic [WIDTH-1:0] row_5,
  output logic [WIDTH-1:0] row_6,
  output logic [WIDTH-1:0] row_7,
  output logic             frame_update,
  output logic             frame_error
);

  localparam int unsigned     IdxW    = $clog2(ROWS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ROWS - 1);

  state_e                     state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [ROWS-1:0][WIDTH-1:0] shadow_rows;
  logic [ROWS-1:0][WIDTH-1:0] rows_q;
  logic                       xfer, swap, err;
  logic                       update_q, error_q;

  // in_ready is a pure decode of the state register: no path from in_valid.
  assign in_ready = (state_q == StFill);
  assign xfer     = in_valid && in_ready;

  glyph_shadow_buffer #(
    .ROWS  (ROWS),
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (xfer),
    .wr_idx  (idx_q),
    .wr_data (in_data),
    .rd_rows (shadow_rows)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    swap    = 1'b0;
    err     = 1'b0;
    case (state_q)
      StFill: begin
        if (xfer) begin
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (in_last) begin
              state_d = StPending;
            end else begin
              err = 1'b1;
            end
          end else if (in_last) begin
            idx_d = '0;
            err   = 1'b1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StPending: begin
        // A sync seen during the last-byte transfer is ignored: only PENDING cycles count.
        if (frame_sync || !SYNC_SWAP) begin
          swap    = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFill;
      idx_q    <= '0;
      update_q <= 1'b0;
      error_q  <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        rows_q[i] <= BlankRow;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      update_q <= swap;
      error_q  <= err;
      if (swap) begin
        rows_q <= shadow_rows;
      end
    end
  end

  assign frame_update = update_q;
  assign frame_error  = error_q;

  assign row_0 = rows_q[0];
  assign row_1 = rows_q[1];
  assign row_2 = rows_q[2];
  assign row_3 = rows_q[3];
  assign row_4 = rows_q[4];
  assign row_5 = rows_q[5];
  assign row_6 = rows_q[6];
  assign row_7 = rows_q[7];

endmodule

// File: tb/tb_glyph_row_loader.sv
// Drives a synced-swap and a free-swap loader with shared stimulus and checks both
// every cycle against a frame-level model (byte count, pending frame, active frame).
module tb_glyph_row_loader;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       frame_sync;

  // Index 0: SYNC_SWAP = 0, index 1: SYNC_SWAP = 1.
  logic       rdy [2];
  logic       upd [2];
  logic       err [2];
  logic [7:0] rw  [2][8];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance.
  int         cnt   [2];
  bit         pend  [2];
  logic [7:0] shd   [2][8];
  logic [7:0] act   [2][8];
  bit         e_upd [2];
  bit         e_err [2];

  logic [7:0] frame_a [8];
  logic [7:0] frame_f [8];
  logic [7:0] frame_c [8];

  glyph_row_loader #(.SYNC_SWAP(1'b0)) u_dut_free (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (rdy[0]),
    .frame_sync   (frame_sync),
    .row_0        (rw[0][0]),
    .row_1        (rw[0][1]),
    .row_2        (rw[0][2]),
    .row_3        (rw[0][3]),
    .row_4        (rw[0][4]),
    .row_5        (rw[0][5]),
    .row_6        (rw[0][6]),
    .row_7        (rw[0][7]),
    .frame_update (upd[0]),
    .frame_error  (err[0])
  );

  glyph_row_loader #(.SYNC_SWAP(1'b1)) u_dut_sync (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (rdy[1]),
    .frame_sync   (frame_sync),
    .row_0        (rw[1][0]),
    .row_1        (rw[1][1]),
    .row_2        (rw[1][2]),
    .row_3        (rw[1][3]),
    .row_4        (rw[1][4]),
    .row_5        (rw[1][5]),
    .row_6        (rw[1][6]),
    .row_7        (rw[1][7]),
    .frame_update (upd[1]),
    .frame_error  (err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt[m]   = 0;
      pend[m]  = 1'b0;
      e_upd[m] = 1'b0;
      e_err[m] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        shd[m][k] = 8'h00;
        act[m][k] = 8'h00;
      end
    end
  endtask

  // One clock edge of the frame-level behaviour, from the inputs held before the edge.
  task automatic model_step(input int m);
    e_upd[m] = 1'b0;
    e_err[m] = 1'b0;
    if (!pend[m]) begin
      if (in_valid) begin
        shd[m][cnt[m]] = in_data;
        cnt[m]++;
        if (in_last && cnt[m] == 8) begin
          pend[m] = 1'b1;
          cnt[m]  = 0;
        end else if (in_last || cnt[m] == 8) begin
          e_err[m] = 1'b1;
          cnt[m]   = 0;
        end
      end
    end else if (frame_sync || m == 0) begin
      for (int k = 0; k < 8; k++) act[m][k] = shd[m][k];
      e_upd[m] = 1'b1;
      pend[m]  = 1'b0;
    end
  endtask

  task automatic check_dut(input int m);
    logic [63:0] o, e;
    for (int k = 0; k < 8; k++) begin
      o[k*8 +: 8] = rw[m][k];
      e[k*8 +: 8] = act[m][k];
    end
    check_eq($sformatf("m%0d_rows", m), o, e);
    check_eq($sformatf("m%0d_ready", m), {63'b0, rdy[m]}, {63'b0, !pend[m]});
    check_eq($sformatf("m%0d_update", m), {63'b0, upd[m]}, {63'b0, e_upd[m]});
    check_eq($sformatf("m%0d_error", m), {63'b0, err[m]}, {63'b0, e_err[m]});
  endtask

  task automatic check_reset_vals(input int m);
    logic [63:0] o;
    for (int k = 0; k < 8; k++) o[k*8 +: 8] = rw[m][k];
    check_eq($sformatf("m%0d_rst_rows", m), o, 64'h0);
    check_eq($sformatf("m%0d_rst_ready", m), {63'b0, rdy[m]}, 64'h1);
    check_eq($sformatf("m%0d_rst_update", m), {63'b0, upd[m]}, 64'h0);
    check_eq($sformatf("m%0d_rst_error", m), {63'b0, err[m]}, 64'h0);
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic l, input logic s);
    in_valid   = v;
    in_data    = d;
    in_last    = l;
    frame_sync = s;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0, s);
  endtask

  task automatic send_frame(input logic [7:0] b [8], input int n, input int last_at);
    for (int i = 0; i < n; i++) tick(1'b1, b[i], (i == last_at), 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    in_last  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    frame_a = '{8'h00, 8'h4A, 8'h4A, 8'h48, 8'h7A, 8'h4A, 8'h4A, 8'h00};
    frame_f = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) frame_c[i] = 8'(8'h10 + i * 8'h11);

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    frame_sync = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    reset = 1'b0;

    // Glyph frame; the sync coincident with the last byte must be ignored.
    send_frame(frame_a, 7, -1);
    tick(1'b1, frame_a[7], 1'b1, 1'b1);
    idle(4, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);

    // Short frame, then a clean all-FF frame.
    send_frame(frame_f, 3, 2);
    idle(2, 1'b0);
    send_frame(frame_f, 8, 7);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Long frame, then a clean frame must land starting at row 0.
    send_frame(frame_a, 8, -1);
    idle(1, 1'b1);
    send_frame(frame_c, 8, 7);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Backpressure: valid held high, frame 1 waits >20 cycles for its sync.
    for (int c = 0; c < 70; c++) begin
      tick(1'b1, 8'($urandom), (cnt[1] == 7), (c == 35 || c == 62));
    end
    idle(3, 1'b0);

    // Reset during byte 5 of a frame.
    send_frame(frame_c, 4, -1);
    async_reset(1'b1, frame_c[4]);
    idle(1, 1'b0);
    send_frame(frame_a, 8, 7);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Reset while the synced loader is pending with non-zero active rows.
    send_frame(frame_f, 8, 7);
    idle(2, 1'b0);
    async_reset(1'b0, 8'h00);
    idle(1, 1'b0);
    send_frame(frame_c, 8, 7);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Random traffic with occasional framing faults and random syncs.
    for (int c = 0; c < 400; c++) begin
      logic v, l, s;
      v = ($urandom_range(0, 9) < 7);
      if (cnt[1] == 7) l = ($urandom_range(0, 15) != 0);
      else             l = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 9) == 0);
      tick(v, 8'($urandom), l, s);
    end
    idle(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
